// File: rtl/hub_fp_pkg.sv
// hub_fp_pkg: shared types and constants for the HUB FP16 datapath.
// Provides the HUB16 operand struct, format constants, the add/sub FSM
// state type, the status flag struct and the working-significand helper.
package hub_fp_pkg;

    localparam int unsigned HUB16_BIAS    = 15;
    localparam int unsigned HUB16_EMAX    = 31;
    localparam logic [14:0] HUB16_INF_MAG = 15'h7FFF;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } hub16_t;

    typedef enum logic [2:0] {
        HUB_IDLE  = 3'd0,
        HUB_ALIGN = 3'd1,
        HUB_ADD   = 3'd2,
        HUB_NORM  = 3'd3,
        HUB_DONE  = 3'd4
    } hub_addsub_state_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } hub_status_t;

    // Working significand: hidden 1, fraction, HUB implicit LSB, two guard zeros.
    function automatic logic [13:0] hub_work_sig(input logic [9:0] frac);
        return {1'b1, frac, 1'b1, 2'b00};
    endfunction

endpackage

// File: rtl/hub_lzc.sv
// hub_lzc: combinational leading-zero counter for the 15-bit ADD result.
// Ports:
//   vec_i    [14:0]  value to scan, bit 14 is the MSB
//   lz_cnt_o [3:0]   number of zeros above the first 1 (15 when vec_i is 0)
module hub_lzc (
    input  logic [14:0] vec_i,
    output logic [3:0]  lz_cnt_o
);

    always_comb begin
        lz_cnt_o = 4'd15;
        // Ascending scan: the highest set bit is written last and wins.
        for (int unsigned i = 0; i < 15; i++) begin
            if (vec_i[i]) begin
                lz_cnt_o = 4'(14 - i);
            end
        end
    end

endmodule

// File: rtl/hub_fp16_addsub_unit.sv
// hub_fp16_addsub_unit: multi-cycle HUB FP16 adder/subtractor (IDLE, ALIGN,
// ADD, NORM, DONE) behind a valid/ready request/response handshake.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   operands_i[1], operands_i[2]  operands A and B ([0] unused)
//   op_mod_i                      0 = A+B, 1 = A-B
//   tag_i / tag_o                 tag carried from request to response
//   in_valid_i / in_ready_o       request handshake
//   flush_i                       synchronous abort of the in-flight op
//   result_o, status_o            result and {NV,DZ,OF,UF,NX}
//   out_valid_o / out_ready_i     response handshake
//   busy_o                        high outside IDLE
// Build option: HUB_ADD_STATUS_EN enables the status flags; without it
// status_o is tied to zero.
module hub_fp16_addsub_unit
    import hub_fp_pkg::*;
#(
    parameter int unsigned OPW     = 16,
    parameter type         TagType = logic
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [2:0][OPW-1:0] operands_i,
    input  logic                op_mod_i,
    input  TagType              tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output logic [OPW-1:0]      result_o,
    output logic [4:0]          status_o,
    output TagType              tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    hub_addsub_state_e state_q, state_d;

    hub16_t      a_q, b_q;
    logic        op_mod_q;
    TagType      tag_q;
    logic        big_sign_q, eff_sub_q, spec_q;
    logic [4:0]  big_exp_q;
    logic [13:0] big_sig_q, small_sig_q;
    logic [15:0] spec_res_q;
    logic [14:0] sum_q;

    logic unused_op0;
    assign unused_op0 = ^operands_i[0];

    // ALIGN stage
    logic        b_sign_eff, a_inf, b_inf, a_zero, b_zero, a_big, eff_sub;
    logic        big_sign, spec, spec_nv;
    logic [4:0]  big_exp, small_exp, exp_diff;
    logic [13:0] big_sig, small_sh;
    logic [15:0] spec_res;

    always_comb begin
        b_sign_eff = b_q.sign ^ op_mod_q;
        a_inf      = (a_q.exp == 5'(HUB16_EMAX));
        b_inf      = (b_q.exp == 5'(HUB16_EMAX));
        a_zero     = (a_q.exp == '0);
        b_zero     = (b_q.exp == '0);
        a_big      = ({a_q.exp, a_q.frac} >= {b_q.exp, b_q.frac});
        eff_sub    = a_q.sign ^ b_sign_eff;
        big_sign   = a_big ? a_q.sign : b_sign_eff;
        big_exp    = a_big ? a_q.exp : b_q.exp;
        small_exp  = a_big ? b_q.exp : a_q.exp;
        big_sig    = hub_work_sig(a_big ? a_q.frac : b_q.frac);
        exp_diff   = big_exp - small_exp;
        small_sh   = (exp_diff >= 5'd14) ? '0
                   : (hub_work_sig(a_big ? b_q.frac : a_q.frac) >> exp_diff);

        spec     = 1'b1;
        spec_nv  = 1'b0;
        spec_res = '0;
        if (a_inf || b_inf) begin
            if (a_inf && b_inf && (a_q.sign != b_sign_eff)) begin
                spec_res = {1'b0, HUB16_INF_MAG};
                spec_nv  = 1'b1;
            end else if (a_inf) begin
                spec_res = {a_q.sign, HUB16_INF_MAG};
            end else begin
                spec_res = {b_sign_eff, HUB16_INF_MAG};
            end
        end else if (a_zero && b_zero) begin
            spec_res = {a_q.sign & b_sign_eff, 15'h0000};
        end else if (a_zero) begin
            spec_res = {b_sign_eff, b_q.exp, b_q.frac};
        end else if (b_zero) begin
            spec_res = a_q;
        end else if (eff_sub && ({a_q.exp, a_q.frac} == {b_q.exp, b_q.frac})) begin
            spec_res = '0;
        end else begin
            spec = 1'b0;
        end
    end

    // NORM stage: shifting by the LZC count puts the leading 1 at bit 14, so
    // the exponent is big_exp + 1 - count; a carry (count 0) is the +1 case.
    logic [3:0]  lz_cnt;
    logic [14:0] norm_sig;
    logic [6:0]  exp_t;
    logic        ovf, udf;
    logic [15:0] norm_res;

    hub_lzc u_lzc (
        .vec_i    (sum_q),
        .lz_cnt_o (lz_cnt)
    );

    always_comb begin
        norm_sig = sum_q << lz_cnt;
        exp_t    = {2'b00, big_exp_q} + 7'd1 - {3'b000, lz_cnt};
        ovf      = !exp_t[6] && (exp_t >= 7'(HUB16_EMAX));
        udf      = exp_t[6] || (exp_t == '0);
        if (spec_q) begin
            norm_res = spec_res_q;
        end else if (ovf) begin
            norm_res = {big_sign_q, HUB16_INF_MAG};
        end else if (udf) begin
            norm_res = {big_sign_q, 15'h0000};
        end else begin
            norm_res = {big_sign_q, exp_t[4:0], norm_sig[13:4]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUB_IDLE:  if (in_valid_i)  state_d = HUB_ALIGN;
            HUB_ALIGN: state_d = HUB_ADD;
            HUB_ADD:   state_d = HUB_NORM;
            HUB_NORM:  state_d = HUB_DONE;
            HUB_DONE:  if (out_ready_i) state_d = HUB_IDLE;
            default:   state_d = HUB_IDLE;
        endcase
        if (flush_i) state_d = HUB_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HUB_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_mod_q    <= 1'b0;
            tag_q       <= '0;
            big_sign_q  <= 1'b0;
            eff_sub_q   <= 1'b0;
            spec_q      <= 1'b0;
            big_exp_q   <= '0;
            big_sig_q   <= '0;
            small_sig_q <= '0;
            spec_res_q  <= '0;
            sum_q       <= '0;
            result_o    <= '0;
            tag_o       <= '0;
        end else begin
            state_q <= state_d;
            if (!flush_i) begin
                case (state_q)
                    HUB_IDLE: if (in_valid_i) begin
                        a_q      <= operands_i[1];
                        b_q      <= operands_i[2];
                        op_mod_q <= op_mod_i;
                        tag_q    <= tag_i;
                    end
                    HUB_ALIGN: begin
                        big_sign_q  <= big_sign;
                        eff_sub_q   <= eff_sub;
                        big_exp_q   <= big_exp;
                        big_sig_q   <= big_sig;
                        small_sig_q <= small_sh;
                        spec_q      <= spec;
                        spec_res_q  <= spec_res;
                    end
                    HUB_ADD: begin
                        sum_q <= eff_sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                                           : ({1'b0, big_sig_q} + {1'b0, small_sig_q});
                    end
                    HUB_NORM: begin
                        result_o <= norm_res;
                        tag_o    <= tag_q;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HUB_ADD_STATUS_EN
    hub_status_t status_q, norm_st;
    logic        spec_nv_q;

    always_comb begin
        norm_st = '0;
        if (spec_q) begin
            norm_st.nv = spec_nv_q;
        end else if (ovf) begin
            norm_st.of = 1'b1;
            norm_st.nx = 1'b1;
        end else if (udf) begin
            norm_st.uf = 1'b1;
            norm_st.nx = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q  <= '0;
            spec_nv_q <= 1'b0;
        end else if (!flush_i) begin
            if (state_q == HUB_ALIGN) spec_nv_q <= spec_nv;
            if (state_q == HUB_NORM)  status_q  <= norm_st;
        end
    end

    assign status_o = status_q;
`else
    logic unused_nv;
    assign unused_nv = spec_nv;
    assign status_o  = '0;
`endif

    assign in_ready_o  = (state_q == HUB_IDLE);
    assign out_valid_o = (state_q == HUB_DONE);
    assign busy_o      = (state_q != HUB_IDLE);

endmodule

// File: tb/tb_hub_fp16_addsub_unit.sv
module tb_hub_fp16_addsub_unit;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [2:0][15:0]  operands = '0;
    logic              op_mod = 1'b0;
    logic              tag_in = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [15:0]       result;
    logic [4:0]        status;
    logic              tag_out;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    hub_fp16_addsub_unit #(
        .OPW     (16),
        .TagType (logic)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .operands_i  (operands),
        .op_mod_i    (op_mod),
        .tag_i       (tag_in),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .flush_i     (flush),
        .result_o    (result),
        .status_o    (status),
        .tag_o       (tag_out),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
    );

`ifdef HUB_ADD_STATUS_EN
    localparam logic [4:0] ST_MASK = 5'h1F;
`else
    localparam logic [4:0] ST_MASK = 5'h00;
`endif
    localparam logic [4:0] ST_NV    = 5'b10000;
    localparam logic [4:0] ST_OF_NX = 5'b00101;
    localparam logic [4:0] ST_UF_NX = 5'b00011;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic mod, input logic tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        operands[0] = 16'hDEAD;
        operands[1] = a;
        operands[2] = b;
        op_mod      = mod;
        tag_in      = tag;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic mod, input logic tag, input logic [15:0] exp_res,
                          input logic [4:0] exp_st, input int hold);
        int n = 0;
        issue(a, b, mod, tag);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, 32'd3);
        check({name, "_result"}, {16'd0, result}, {16'd0, exp_res});
        check({name, "_status"}, {27'd0, status}, {27'd0, exp_st & ST_MASK});
        check({name, "_tag"}, {31'd0, tag_out}, {31'd0, tag});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_result"}, {16'd0, result}, {16'd0, exp_res});
            check({name, "_hold_tag"}, {31'd0, tag_out}, {31'd0, tag});
            check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
        check({name, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        mod;
        logic        tag;
        logic [15:0] res;
        logic [4:0]  st;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic seen;
        vecs = '{
            '{16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h4000, 5'b00000},
            '{16'h4000, 16'h3C00, 1'b1, 1'b0, 16'h3C00, 5'b00000},
            '{16'h4200, 16'h4000, 1'b1, 1'b1, 16'h3C00, 5'b00000},
            '{16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 16'h7FFF, ST_NV},
            '{16'h7BFF, 16'h7BFF, 1'b0, 1'b1, 16'h7FFF, ST_OF_NX},
            '{16'h3C00, 16'h3C00, 1'b1, 1'b0, 16'h0000, 5'b00000},
            '{16'h0000, 16'h3C00, 1'b1, 1'b1, 16'hBC00, 5'b00000},
            '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 5'b00000},
            '{16'h8000, 16'h0000, 1'b1, 1'b1, 16'h8000, 5'b00000},
            '{16'h0800, 16'h0401, 1'b1, 1'b0, 16'h0000, ST_UF_NX},
            '{16'h3C00, 16'h0400, 1'b0, 1'b1, 16'h3C00, 5'b00000},
            '{16'h3C00, 16'hC000, 1'b0, 1'b0, 16'hBC00, 5'b00000},
            '{16'hFC00, 16'h3C00, 1'b1, 1'b1, 16'hFFFF, 5'b00000},
            '{16'h3C00, 16'h7C00, 1'b1, 1'b0, 16'hFFFF, 5'b00000},
            '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b00000},
            '{16'h3E00, 16'h3C00, 1'b0, 1'b1, 16'h4100, 5'b00000}
        };

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_status", {27'd0, status}, 32'd0);
        check("rst_tag", {31'd0, tag_out}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mod,
                   vecs[i].tag, vecs[i].res, vecs[i].st, (i == 0) ? 3 : 0);
        end

        // Flush while in ALIGN
        issue(16'h3C00, 16'h3C00, 1'b0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);

        // Flush beats a simultaneous request
        @(negedge clk);
        operands[1] = 16'h3C00;
        operands[2] = 16'h3C00;
        in_valid    = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_vs_valid_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset while in NORM
        issue(16'h3C00, 16'h3C00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_status", {27'd0, status}, 32'd0);
        check("midrst_tag", {31'd0, tag_out}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        run_op("post_reset", 16'h3E00, 16'h3C00, 1'b0, 1'b1, 16'h4100, 5'b00000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hub_fp16_addsub_unit.md
# hub_fp16_addsub_unit

Multi-cycle HUB-format FP16 adder/subtractor. It is the responder side of the FPU operation handshake: it accepts operations from an initiator (core or bench) through the valid/ready request channel and returns a tagged result through the valid/ready response channel. It sits beside `fpnew_top` as a compact HUB-only ADD unit for FP16 paths, and is compatible with the same bench driver.

## Interface
- `OPW`, default 16: operand/result width; only 16 supported.
- `TagType`, default `logic`: tag passed unchanged from request to response.
- `clk_i`, input, 1: clock, rising edge.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `operands_i`, input, 3x16: operand A is `[1]`, operand B is `[2]`; `[0]` is ignored.
- `op_mod_i`, input, 1: 0 = A+B, 1 = A−B (inverts B's sign).
- `tag_i`, input, TagType: request tag.
- `in_valid_i`, input, 1: request valid.
- `in_ready_o`, output, 1: request ready.
- `flush_i`, input, 1: synchronous abort.
- `result_o`, output, 16: HUB FP16 result.
- `status_o`, output, 5: {NV, DZ, OF, UF, NX}.
- `tag_o`, output, TagType: response tag.
- `out_valid_o`, output, 1: response valid.
- `out_ready_i`, input, 1: response ready.
- `busy_o`, output, 1: high in any state other than IDLE.

## Operation
- **Format.** Bits are {s, e[4:0], f[9:0]}, bias 15. Value = (−1)^s·2^(e−15)·1.f1; the implicit ILSB = 1 gives 12 significand bits. e=0 means zero; there are no subnormals. e=31 means infinity.
- **FSM:** IDLE → ALIGN → ADD → NORM → DONE → IDLE.
- **IDLE.** `in_ready_o`=1. On `in_valid_i`, the unit captures the operands, `op_mod_i` and `tag_i`.
- **ALIGN.** Applies `op_mod_i` to B's sign. Larger magnitude is chosen by comparing {e,f}. Each working significand is {1, f, 1, 2'b00}, 14 bits. The smaller operand is shifted right by the exponent difference, saturating at 14; bits shifted out are dropped.
- **ADD.** Computes a 15-bit sum, or the difference larger−smaller. Result sign = sign of the larger operand.
- **NORM.**
  - On carry: shift right 1, exp+1.
  - Otherwise: shift left by the `hub_lzc` count and subtract that count from the exponent.
  - The 10 bits below the leading 1 form f; all lower bits are truncated. Truncation is HUB round-to-nearest.
- **DONE.** `out_valid_o`=1, with `result_o`, `tag_o` and `status_o` held stable. On `out_ready_i`, return to IDLE.
- **Special cases:**
  - Any infinity operand: result is inf, encoded {s, 15'h7FFF}.
  - Opposite-sign infinities: result 16'h7FFF, NV=1.
  - Exact cancellation: 16'h0000.
  - One zero operand: result is the other operand, with its effective sign.
  - Both zero: 16'h0000, or 16'h8000 if both effective signs are negative.
  - Result exponent ≥31: inf with OF=1 and NX=1.
  - Result exponent ≤0: signed zero with UF=1 and NX=1.
- **`flush_i`** from any state: next state IDLE, `out_valid_o`=0, and the in-flight operation is discarded. Flush wins over a simultaneous `in_valid_i`; no request is accepted in that cycle.

## Timing
- **Reset values:** state IDLE, `in_ready_o`=1, `out_valid_o`=0, `busy_o`=0, `result_o`=0, `status_o`=0, `tag_o`=0.
- **Latency.** Request accepted at edge E → `out_valid_o` is high after edge E+3 and is first samplable at E+4.
- **Throughput.** One operation in flight. `in_ready_o`=0 from E until the edge completing the response handshake. `in_ready_o` returns high the cycle after that edge. Maximum rate is one operation per 5 cycles.
- **Back-pressure.** With `out_ready_i` low, DONE holds indefinitely and all outputs stay stable.
- **Reset mid-operation.** Asserting `rst_ni` low mid-operation immediately forces the reset values; the operation is lost.

## Configuration
- **`HUB_ADD_STATUS_EN` defined:** `status_o` reports NV, OF, UF and NX as above; DZ is always 0.
- **Not defined:** `status_o` is tied to 5'b0 and the flag logic is removed. `result_o` is identical in both builds.

## Structure
- **Package `hub_fp_pkg`:**
  - `hub16_t` struct {sign, exp, frac}.
  - `HUB16_BIAS`=15.
  - `HUB16_EMAX`=31.
  - `HUB16_INF_MAG`=15'h7FFF.
  - `hub_addsub_state_e` enum.
  - `hub_status_t`.
- **Sub-module `hub_lzc`:** combinational 15-bit leading-zero counter with a 4-bit count output, used by NORM.

## Test plan
- 3C00 + 3C00, op_mod=0, tag=1 → 4000, status 0, tag_o=1, `out_valid_o` first sampled 4 edges after accept.
- 4000 − 3C00 (op_mod=1) → 3C00; 4200 − 4000 → 3C00.
- FFFF + 7FFF → 7FFF with NV=1 when the macro is defined, status 0 when it is not.
- 7BFF + 7BFF → 7FFF with OF=1 and NX=1; 3C00 − 3C00 → 0000.
- Hold `out_ready_i` low 3 cycles in DONE: `result_o` and `tag_o` stay constant and `in_ready_o` stays 0. Release: handshake completes, `in_ready_o`=1 the next cycle.
- Assert `flush_i` during ALIGN: `out_valid_o` is never raised and the unit is in IDLE next cycle. `rst_ni` low during NORM: all outputs take their reset values asynchronously.
